// File: rtl/m_regfile.sv
`default_nettype none
// ============================================================================
// m_regfile : 32 x XLEN register file, pending-write scoreboard, reset scrub.
// Option    : MARISCAL_REGFILE_BYPASS_EN forwards same-cycle writeback to reads.
// Revision  : 1.0
// ============================================================================
module m_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs_sel,
    output logic [XLEN-1:0] rs_in,
    input  logic [4:0]      rq_sel,
    output logic [XLEN-1:0] rq_in,
    output logic            rs_busy,
    output logic            rq_busy,
    input  logic            rsv_valid,
    input  logic [4:0]      rsv_rd,
    output logic            rsv_ready,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    output logic            wb_err
);

    typedef enum logic [0:0] {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic [31:0]     busy_q, busy_d;
    logic            wb_err_q, wb_err_d;
    logic [XLEN-1:0] regs_q [32];

    logic            w_run;
    logic            w_wb_fire;
    logic            w_rsv_fire;
    logic            w_reg_we;
    logic [4:0]      w_reg_waddr;
    logic [XLEN-1:0] w_reg_wdata;

    // A busy destination may be re-reserved only when its writeback retires it this same cycle.
    always_comb begin
        w_run      = (state_q == RUN);
        w_wb_fire  = w_run && wb_valid;
        wb_ready   = w_run;
        rsv_ready  = w_run && (!busy_q[rsv_rd] ||
                     (w_wb_fire && (wb_rd == rsv_rd) && (rsv_rd != 5'd0)));
        w_rsv_fire = rsv_valid && rsv_ready;
        wb_err     = wb_err_q;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        wb_err_d    = wb_err_q;
        w_reg_we    = 1'b0;
        w_reg_waddr = idx_q;
        w_reg_wdata = '0;
        case (state_q)
            SCRUB: begin
                w_reg_we = 1'b1;
                idx_d    = idx_q + 5'd1;
                if (idx_q == 5'd31) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_wb_fire && (wb_rd != 5'd0)) begin
                    w_reg_we      = 1'b1;
                    w_reg_waddr   = wb_rd;
                    w_reg_wdata   = wb_data;
                    busy_d[wb_rd] = 1'b0;
                    if (!busy_q[wb_rd]) begin
                        wb_err_d = 1'b1;
                    end
                end
                // Applied after the clear so a same-rd reservation leaves the register busy.
                if (w_rsv_fire && (rsv_rd != 5'd0)) begin
                    busy_d[rsv_rd] = 1'b1;
                end
            end
            default: state_d = SCRUB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= SCRUB;
            idx_q    <= 5'd0;
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_reg_we) begin
            regs_q[w_reg_waddr] <= w_reg_wdata;
        end
    end

    always_comb begin
        rs_in   = '0;
        rq_in   = '0;
        rs_busy = 1'b1;
        rq_busy = 1'b1;
        if (w_run) begin
            rs_in   = (rs_sel == 5'd0) ? '0 : regs_q[rs_sel];
            rq_in   = (rq_sel == 5'd0) ? '0 : regs_q[rq_sel];
            rs_busy = busy_q[rs_sel];
            rq_busy = busy_q[rq_sel];
`ifdef MARISCAL_REGFILE_BYPASS_EN
            if (w_wb_fire && (wb_rd != 5'd0) && (wb_rd == rs_sel)) begin
                rs_in   = wb_data;
                rs_busy = 1'b0;
            end
            if (w_wb_fire && (wb_rd != 5'd0) && (wb_rd == rq_sel)) begin
                rq_in   = wb_data;
                rq_busy = 1'b0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_m_regfile.sv
`default_nettype none
// ============================================================================
// tb_m_regfile : directed scenarios plus randomized traffic against a model.
// Revision     : 1.0
// ============================================================================
module tb_m_regfile;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4:0]      rs_sel, rq_sel, rsv_rd, wb_rd;
    logic            rsv_valid, wb_valid;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] rs_in, rq_in;
    logic            rs_busy, rq_busy, rsv_ready, wb_ready, wb_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain arrays plus a count of scrub cycles still owed.
    logic [XLEN-1:0] m_regs [32];
    bit              m_busy [32];
    bit              m_err;
    int              m_scrub_left = 32;

    always #5 clk = ~clk;

    m_regfile #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_sel    (rs_sel),
        .rs_in     (rs_in),
        .rq_sel    (rq_sel),
        .rq_in     (rq_in),
        .rs_busy   (rs_busy),
        .rq_busy   (rq_busy),
        .rsv_valid (rsv_valid),
        .rsv_rd    (rsv_rd),
        .rsv_ready (rsv_ready),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .wb_err    (wb_err)
    );

    function automatic bit m_fwd(input logic [4:0] sel);
`ifdef MARISCAL_REGFILE_BYPASS_EN
        return (m_scrub_left == 0) && wb_valid && (wb_rd != 0) && (wb_rd == sel);
`else
        return (sel == 5'd31) && 1'b0;
`endif
    endfunction

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] sel);
        if (m_scrub_left != 0) return '0;
        if (m_fwd(sel))        return wb_data;
        if (sel == 0)          return '0;
        return m_regs[sel];
    endfunction

    function automatic bit m_busy_out(input logic [4:0] sel);
        if (m_scrub_left != 0) return 1'b1;
        if (m_fwd(sel))        return 1'b0;
        return m_busy[sel];
    endfunction

    function automatic bit m_rsv_ready();
        if (m_scrub_left != 0) return 1'b0;
        if (!m_busy[rsv_rd])   return 1'b1;
        return wb_valid && (wb_rd == rsv_rd) && (rsv_rd != 0);
    endfunction

    task automatic model_edge();
        bit rr;
        rr = m_rsv_ready();
        if (!rst_n) begin
            m_scrub_left = 32;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_err = 1'b0;
        end else if (m_scrub_left > 0) begin
            m_regs[32 - m_scrub_left] = '0;
            m_scrub_left--;
        end else begin
            if (wb_valid && wb_rd != 0) begin
                if (!m_busy[wb_rd]) m_err = 1'b1;
                m_regs[wb_rd] = wb_data;
                m_busy[wb_rd] = 1'b0;
            end
            if (rsv_valid && rr && rsv_rd != 0) m_busy[rsv_rd] = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rs_sel = '0; rq_sel = '0; rsv_valid = 1'b0; rsv_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic scrub_wait(output int low);
        low = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (wb_ready === 1'b1 && rsv_ready === 1'b1) break;
            low++;
            tick();
        end
    endtask

    task automatic test_reset();
        int low;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        #1;
        n_tests++;
        if (rsv_ready !== 1'b0 || wb_ready !== 1'b0 || rs_busy !== 1'b1 || rq_busy !== 1'b1 ||
            rs_in !== '0 || rq_in !== '0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rsv_ready=%b wb_ready=%b rs_busy=%b rq_busy=%b rs_in=%h rq_in=%h wb_err=%b, want 0 0 1 1 0 0 0",
                     rsv_ready, wb_ready, rs_busy, rq_busy, rs_in, rq_in, wb_err);
        end
        rst_n = 1'b1;
        scrub_wait(low);
        n_tests++;
        if (low != 32) begin
            n_fail++;
            $display("FAIL scrub_latency: ready low for %0d cycles, want 32", low);
        end
    endtask

    task automatic test_scrub_reads();
        for (int i = 0; i < 32; i++) begin
            rs_sel = 5'(i);
            rq_sel = 5'(31 - i);
            #1;
            n_tests++;
            if (rs_in !== '0 || rq_in !== '0 || rs_busy !== 1'b0 || rq_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL scrub_read_%0d: rs_in=%h rq_in=%h rs_busy=%b rq_busy=%b, want 0 0 0 0",
                         i, rs_in, rq_in, rs_busy, rq_busy);
            end
        end
        idle();
    endtask

    task automatic test_reserve_wb();
        logic [XLEN-1:0] exp_in;
        logic            exp_busy;
        rs_sel = 5'd5; rsv_valid = 1'b1; rsv_rd = 5'd5;
        #1;
        n_tests++;
        if (rsv_ready !== 1'b1 || rs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rsv_r5_accept: rsv_ready=%b rs_busy=%b, want 1 0", rsv_ready, rs_busy);
        end
        tick();
        idle();
        rs_sel = 5'd5;
        #1;
        n_tests++;
        if (rs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL r5_busy_after_rsv: rs_busy=%b, want 1", rs_busy);
        end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
        #1;
`ifdef MARISCAL_REGFILE_BYPASS_EN
        exp_in = 32'hDEAD_BEEF; exp_busy = 1'b0;
`else
        exp_in = 32'h0;         exp_busy = 1'b1;
`endif
        n_tests++;
        if (rs_in !== exp_in || rs_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL r5_during_wb: rs_in=%h rs_busy=%b, want %h %b", rs_in, rs_busy, exp_in, exp_busy);
        end
        tick();
        idle();
        rs_sel = 5'd5;
        #1;
        n_tests++;
        if (rs_in !== 32'hDEAD_BEEF || rs_busy !== 1'b0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL r5_after_wb: rs_in=%h rs_busy=%b wb_err=%b, want deadbeef 0 0", rs_in, rs_busy, wb_err);
        end
    endtask

    task automatic test_waw();
        idle();
        rsv_valid = 1'b1; rsv_rd = 5'd5;
        tick();
        #1;
        n_tests++;
        if (rsv_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL waw_stall: rsv_ready=%b, want 0", rsv_ready);
        end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hCAFE_0005;
        #1;
        n_tests++;
        if (rsv_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_release_with_wb: rsv_ready=%b, want 1", rsv_ready);
        end
        tick();
        idle();
        rs_sel = 5'd5;
        #1;
        n_tests++;
        if (rs_in !== 32'hCAFE_0005 || rs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL waw_same_cycle: rs_in=%h rs_busy=%b, want cafe0005 1", rs_in, rs_busy);
        end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h0000_0505;
        tick();
        idle();
    endtask

    task automatic test_r0();
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234;
        rsv_valid = 1'b1; rsv_rd = 5'd0;
        #1;
        n_tests++;
        if (rsv_ready !== 1'b1 || rs_in !== '0 || rs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_same_cycle: rsv_ready=%b rs_in=%h rs_busy=%b, want 1 0 0", rsv_ready, rs_in, rs_busy);
        end
        tick();
        idle();
        #1;
        n_tests++;
        if (rs_in !== '0 || rs_busy !== 1'b0 || rq_busy !== 1'b0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_after: rs_in=%h rs_busy=%b rq_busy=%b wb_err=%b, want 0 0 0 0",
                     rs_in, rs_busy, rq_busy, wb_err);
        end
    endtask

    task automatic test_wb_err();
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h77;
        #1;
        n_tests++;
        if (wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_err_before: wb_err=%b, want 0", wb_err);
        end
        tick();
        idle();
        repeat (3) tick();
        rq_sel = 5'd7;
        #1;
        n_tests++;
        if (wb_err !== 1'b1 || rq_in !== 32'h77) begin
            n_fail++;
            $display("FAIL wb_err_sticky: wb_err=%b rq_in=%h, want 1 00000077", wb_err, rq_in);
        end
        idle();
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] exp_in;
        logic            exp_busy;
        rsv_valid = 1'b1; rsv_rd = 5'd3;
        tick();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
        tick();
        idle();
        rsv_valid = 1'b1; rsv_rd = 5'd3;
        tick();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h55; rs_sel = 5'd3; rq_sel = 5'd3;
        #1;
`ifdef MARISCAL_REGFILE_BYPASS_EN
        exp_in = 32'h55; exp_busy = 1'b0;
`else
        exp_in = 32'h11; exp_busy = 1'b1;
`endif
        n_tests++;
        if (rs_in !== exp_in || rs_busy !== exp_busy || rq_in !== exp_in || rq_busy !== exp_busy) begin
            n_fail++;
            $display("FAIL bypass_r3: rs_in=%h rs_busy=%b rq_in=%h rq_busy=%b, want %h %b",
                     rs_in, rs_busy, rq_in, rq_busy, exp_in, exp_busy);
        end
        tick();
        idle();
        rs_sel = 5'd3;
        #1;
        n_tests++;
        if (rs_in !== 32'h55 || rs_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL r3_after_wb: rs_in=%h rs_busy=%b, want 00000055 0", rs_in, rs_busy);
        end
    endtask

    task automatic test_reset_mid();
        int low;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        scrub_wait(low);
        n_tests++;
        if (low != 32) begin
            n_fail++;
            $display("FAIL scrub_restart_mid_scrub: ready low for %0d cycles, want 32", low);
        end
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        idle();
        rs_sel = 5'd9;
        #1;
        n_tests++;
        if (rs_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL r9_busy_before_reset: rs_busy=%b, want 1", rs_busy);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        scrub_wait(low);
        n_tests++;
        if (low != 32) begin
            n_fail++;
            $display("FAIL scrub_restart_in_run: ready low for %0d cycles, want 32", low);
        end
        rs_sel = 5'd9;
        #1;
        n_tests++;
        if (rs_busy !== 1'b0 || rs_in !== '0 || wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL r9_after_reset: rs_busy=%b rs_in=%h wb_err=%b, want 0 0 0", rs_busy, rs_in, wb_err);
        end
        idle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rs_sel    = 5'($urandom_range(0, 7));
            rq_sel    = 5'($urandom_range(0, 31));
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_rd    = 5'($urandom_range(0, 7));
            wb_valid  = 1'($urandom_range(0, 1));
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            #1;
            n_tests++;
            if (rs_in !== m_read(rs_sel) || rq_in !== m_read(rq_sel) ||
                rs_busy !== m_busy_out(rs_sel) || rq_busy !== m_busy_out(rq_sel) ||
                rsv_ready !== m_rsv_ready() || wb_ready !== 1'b1 || wb_err !== m_err) begin
                n_fail++;
                $display("FAIL random_%0d: rs_in=%h/%h rq_in=%h/%h rs_busy=%b/%b rq_busy=%b/%b rsv_ready=%b/%b wb_ready=%b/1 wb_err=%b/%b (got/want)",
                         c, rs_in, m_read(rs_sel), rq_in, m_read(rq_sel), rs_busy, m_busy_out(rs_sel),
                         rq_busy, m_busy_out(rq_sel), rsv_ready, m_rsv_ready(), wb_ready, wb_err, m_err);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_scrub_reads();
        test_reserve_wb();
        test_waw();
        test_r0();
        test_wb_err();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
`default_nettype wire
